// File: rtl/mem_pkg.sv
// Shared types and the byte-to-word address helper for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_e;

  // Byte address to word index; callers keep only the low ADDR_W bits, which gives the aliasing.
  function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr >> 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int n      = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [n-1:0]      wdata,
  output logic [n-1:0]      rdata
);

  logic [n-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Shared-memory responder: arbitrates data over instruction requests with WAIT wait states.
// Optional MEM_RESPONDER_MISALIGN_EN flags odd data addresses on d_err and suppresses the access.
module mem_responder
  import mem_pkg::*;
#(
  parameter int n      = 16,
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [n-1:0] i_addr,
  output logic         i_ready,
  output logic [n-1:0] i_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [n-1:0] d_addr,
  input  logic [n-1:0] d_wdata,
  output logic         d_ready,
  output logic [n-1:0] d_rdata,
  output logic         d_err
);

  localparam logic [3:0] WAIT_M1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  grant_e            grant_q, grant_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [n-1:0]      wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [n-1:0]      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic [31:0]       i_idx_full, d_idx_full;
  logic [ADDR_W-1:0] i_idx, d_idx, live_idx, acc_idx;
  grant_e            live_grant, acc_grant;
  logic              live_we, live_err, acc_we, acc_err, enter_resp, mem_we;
  logic [n-1:0]      acc_wdata, mem_rdata;
  logic              unused_idx_bits;

  assign i_idx_full      = word_idx(32'(i_addr));
  assign d_idx_full      = word_idx(32'(d_addr));
  assign i_idx           = i_idx_full[ADDR_W-1:0];
  assign d_idx           = d_idx_full[ADDR_W-1:0];
  assign unused_idx_bits = ^{i_idx_full[31:ADDR_W], d_idx_full[31:ADDR_W]};

  assign live_grant = d_req ? GRANT_D : GRANT_I;
  assign live_idx   = d_req ? d_idx : i_idx;
  assign live_we    = d_req & d_we;
`ifdef MEM_RESPONDER_MISALIGN_EN
  assign live_err   = d_req & d_addr[0];
`else
  assign live_err   = 1'b0;
`endif

  // With WAIT=0 the RESP-entry edge is the accepting edge, so the access uses the live request.
  assign acc_grant = (state_q == ST_IDLE) ? live_grant : grant_q;
  assign acc_idx   = (state_q == ST_IDLE) ? live_idx   : idx_q;
  assign acc_we    = (state_q == ST_IDLE) ? live_we    : we_q;
  assign acc_wdata = (state_q == ST_IDLE) ? d_wdata    : wdata_q;
  assign acc_err   = (state_q == ST_IDLE) ? live_err   : err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      grant_q   <= GRANT_I;
      idx_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req || i_req) begin
          grant_d = live_grant;
          idx_d   = live_idx;
          we_d    = live_we;
          wdata_d = d_wdata;
          err_d   = live_err;
          if (WAIT == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = WAIT_M1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_d == ST_RESP);

  // Gating the write with reset keeps a request held during reset from touching the array.
  always_comb begin
    mem_we    = enter_resp && acc_we && !acc_err && reset;
    i_ready_d = enter_resp && (acc_grant == GRANT_I);
    d_ready_d = enter_resp && (acc_grant == GRANT_D);
    d_err_d   = d_ready_d && acc_err;
    i_rdata_d = i_ready_d ? mem_rdata : i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (d_ready_d) begin
      if (acc_we)       d_rdata_d = acc_wdata;
      else if (acc_err) d_rdata_d = '0;
      else              d_rdata_d = mem_rdata;
    end
  end

  mem_array #(.n(n), .ADDR_W(ADDR_W)) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign d_err   = d_err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected responses are queued at drive time
// and popped by a monitor whenever either ready pulses.
module tb_mem_responder;

  localparam int WAIT_C = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ready, d_ready, d_err;
  logic [15:0] i_rdata, d_rdata;

  typedef struct {
    logic        is_d;
    logic        chk_data;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [int];
  int          checks = 0;
  int          failures = 0;

  mem_responder #(.n(16), .ADDR_W(8), .WAIT(WAIT_C)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ready (i_ready),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .d_err   (d_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (i_ready === 1'b1 || d_ready === 1'b1) begin
      checkOutput("ready_overlap", {63'd0, i_ready & d_ready}, 64'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("ready_port", {63'd0, d_ready}, {63'd0, e.is_d});
        if (d_ready) begin
          if (e.chk_data) checkOutput("d_rdata", {48'd0, d_rdata}, {48'd0, e.data});
          checkOutput("d_err", {63'd0, d_err}, {63'd0, e.err});
        end else begin
          checkOutput("i_rdata", {48'd0, i_rdata}, {48'd0, e.data});
        end
      end
    end
  end

  // Drives one request, waits (bounded) for its ready, then checks the latency.
  task automatic applyStimulus(input logic is_d, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic chk_data,
                               input logic [15:0] exp_data, input logic exp_err, input string tag);
    exp_t e;
    int   cycles;
    logic seen;
    e.is_d = is_d; e.chk_data = chk_data; e.data = exp_data; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      cycles++;
      seen = is_d ? d_ready : i_ready;
    end
    d_req = 1'b0;
    i_req = 1'b0;
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(WAIT_C + 1));
  endtask

  task automatic storeWord(input logic [15:0] addr, input logic [15:0] data, input string tag);
    applyStimulus(1'b1, 1'b1, addr, data, 1'b1, data, 1'b0, tag);
    model[int'(addr[8:1])] = data;
  endtask

  task automatic loadWord(input logic [15:0] addr, input string tag);
    applyStimulus(1'b1, 1'b0, addr, 16'h0, 1'b1, model[int'(addr[8:1])], 1'b0, tag);
  endtask

  task automatic fetchWord(input logic [15:0] addr, input string tag);
    applyStimulus(1'b0, 1'b0, addr, 16'h0, 1'b1, model[int'(addr[8:1])], 1'b0, tag);
  endtask

  initial begin
    exp_t e;
    int   cycles;
    logic [15:0] a, v;

    // Reset held with random inputs: every output must stay at zero.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("reset_outputs", {29'd0, i_ready, d_ready, d_err, i_rdata, d_rdata}, 64'd0);
      i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
      i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset = 1'b1;

    storeWord(16'h0010, 16'hBEEF, "store_beef");
    loadWord(16'h0010, "load_beef");
    fetchWord(16'h0010, "fetch_beef");

    // Simultaneous requests: data wins, then the held fetch is served.
    storeWord(16'h0004, 16'h1234, "store_1234");
    storeWord(16'h0020, 16'h5678, "store_5678");
    e.is_d = 1'b1; e.chk_data = 1'b1; e.data = 16'h5678; e.err = 1'b0;
    sb.push_back(e);
    e.is_d = 1'b0; e.chk_data = 1'b1; e.data = 16'h1234; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    i_req = 1'b1; i_addr = 16'h0004;
    cycles = 0;
    for (int k = 0; k < 40 && !d_ready; k++) begin
      @(negedge clk);
      cycles++;
    end
    d_req = 1'b0;
    checkOutput("arb_d_latency", 64'(cycles), 64'(WAIT_C + 1));
    cycles = 0;
    for (int k = 0; k < 40 && !i_ready; k++) begin
      @(negedge clk);
      cycles++;
    end
    i_req = 1'b0;
    checkOutput("arb_i_latency", 64'(cycles), 64'(WAIT_C + 2));

    storeWord(16'h0202, 16'hCAFE, "store_alias");
    loadWord(16'h0002, "load_alias");

    // Reset pulse while a store is in BUSY: the store must be dropped.
    storeWord(16'h0040, 16'h5555, "store_5555");
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hAAAA;
    @(negedge clk);
    reset = 1'b0;
    d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("midreset_outputs", {29'd0, i_ready, d_ready, d_err, i_rdata, d_rdata}, 64'd0);
    end
    reset = 1'b1;
    loadWord(16'h0040, "load_after_reset");

`ifdef MEM_RESPONDER_MISALIGN_EN
    applyStimulus(1'b1, 1'b1, 16'h0011, 16'h1111, 1'b0, 16'h0, 1'b1, "misaligned_store");
`else
    applyStimulus(1'b1, 1'b1, 16'h0011, 16'h1111, 1'b1, 16'h1111, 1'b0, "misaligned_store");
    model[8] = 16'h1111;
`endif
    loadWord(16'h0010, "load_word8");
    fetchWord(16'h0011, "fetch_odd");

    // A few random store/load/fetch triples in an otherwise unused region.
    for (int k = 0; k < 5; k++) begin
      a = 16'h0100 | 16'({$urandom_range(0, 127), 1'b0});
      v = 16'($urandom);
      storeWord(a, v, "rand_store");
      loadWord(a, "rand_load");
      fetchWord(a, "rand_fetch");
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 16-bit CPU datapath: services instruction fetches (PC in, instruction out) and data loads/stores (ALU address, write data in, read data out) from one shared single-port word array. Both ports use a req/ready handshake with a programmable wait-state count. A fixed-priority arbiter grants data over instruction. The block sits between the CPU top level and the memory array, replacing the zero-latency combinational memories.

## Interface
- `n`, 16: data and address width in bits.
- `ADDR_W`, 8: word-address bits; array depth is 2^ADDR_W words.
- `WAIT`, 2: wait states per access, legal range 0..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: instruction fetch request.
- `i_addr` in n: byte address of the fetch.
- `i_ready` out 1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata` out n: fetched instruction word.
- `d_req` in 1: data access request.
- `d_we` in 1: 1 for a store, 0 for a load.
- `d_addr` in n: byte address of the data access.
- `d_wdata` in n: store data.
- `d_ready` out 1: one-cycle pulse; access is complete.
- `d_rdata` out n: load data, or the stored word on a store.
- `d_err` out 1: misaligned-access flag. Pulses with `d_ready`. Tied to 0 when the configuration macro is undefined.

## Operation
- Word index is `addr[ADDR_W:1]`. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+1) bytes.
- FSM states: IDLE, BUSY, RESP. A 4-bit wait counter and a grant flag (I or D) are kept.
- IDLE:
  - Sampling `d_req`=1 grants D. Otherwise, sampling `i_req`=1 grants I.
  - The granted port's address, `d_we` and `d_wdata` are latched.
  - Next state is RESP if `WAIT`=0; otherwise BUSY with counter = `WAIT`-1.
- BUSY: the counter decrements each cycle. An edge with counter = 0 moves the FSM to RESP.
- Entering RESP (the same edge):
  - A read loads the array word into the granted port's rdata register.
  - A store writes the array and loads `d_rdata` with `d_wdata`.
- RESP: the granted port's ready is high for exactly one cycle, and the FSM returns to IDLE. The other port's ready stays 0.
- Requester contract:
  - Hold req, address and write data stable until ready.
  - Deassert req in the cycle following ready, or the request is treated as a new one.
  - The block does not check changes made mid-transaction. The latched values are used.
- Simultaneous requests: D always wins. The pending I request is served in the next IDLE, so `i_req` must stay high. A continuous `d_req` starves I; this is intended, because the CPU stalls on data.
- rdata registers hold their last value between responses.
- The array is not reset. Contents persist across reset.

## Timing
- Reset values: state IDLE, counter 0, `i_ready`=0, `d_ready`=0, `i_rdata`=0, `d_rdata`=0, `d_err`=0.
- Latency: if the accepting edge is e0, ready is high in the cycle after edge e0+`WAIT`. For `WAIT`=0, ready appears in the cycle after the accepting edge.
- Throughput: one transaction per `WAIT`+2 cycles. IDLE always lasts at least one cycle.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and all outputs go to their reset values.
  - A store that has not yet reached the RESP-entry edge is dropped, and the array is unchanged.
- Reset deassertion is synchronised to `clk` externally.

## Configuration
- `MEM_RESPONDER_MISALIGN_EN` defined:
  - A data access with `d_addr[0]`=1 completes with normal latency and `d_err`=1 alongside `d_ready`.
  - A store with this error performs no array write. A load with this error returns `d_rdata`=0.
  - Instruction fetches ignore bit 0.
- Undefined: bit 0 is ignored on both ports and `d_err` is constantly 0.

## Structure
- Package `mem_pkg`: FSM state enum, grant enum (I/D) and the word-index helper function.
- Sub-module `mem_array`: single-port array, `2^ADDR_W` x n, synchronous write and combinational read, instantiated once.
- Top-level `mem_responder` contains only the FSM, counter, latches and output registers.

## Test plan
- Reset: hold `reset`=0 with random inputs. All outputs are 0 and no ready is seen. After release, the first ready follows the rule above.
- `WAIT`=2: store 16'hBEEF to 16'h0010.
  - `d_ready` is high in the cycle after edge e0+2, with `d_rdata`=16'hBEEF.
  - A following load of 16'h0010 returns 16'hBEEF.
  - A fetch via `i_addr`=16'h0010 returns the same word.
- Same-edge `i_req` and `d_req`, where word 16'h0004 holds 16'h1234 and word 16'h0020 holds 16'h5678:
  - D is served first (`d_rdata`=16'h5678).
  - Then I is served (`i_rdata`=16'h1234) with no overlap of the two ready signals.
- Aliasing with `ADDR_W`=8: a store to 16'h0202 reads back at 16'h0002.
- Reset pulse during BUSY of a store of 16'hAAAA to a word holding 16'h5555: no ready is seen, and a later load returns 16'h5555.
- With `MEM_RESPONDER_MISALIGN_EN`: a store to 16'h0011 gives `d_err`=1 and leaves word 8 unchanged. Without the macro, the same store writes word 8 and `d_err`=0.
